timebase_counter: RTL and testbench
===================================

Name: timebase_counter

Overview:
Parametrised successor to the fixed 1024-cycle time-of-day counter. Divides the system clock into half-second and second ticks and keeps an hours/minutes/seconds time plus a free-running seconds accumulator. Adds run/pause control, synchronous clear, time preload, lap capture, and a selectable wrap or saturate mode at the maximum time. Sits between the clock tree and the display and alarm logic; all outputs are registered.

Parameters:
CYCLES_PER_HALF_SEC, 1024, clock cycles per half-second tick; must be ≥2.
HRS_W, 8, width of the hours field.
MAX_HRS, 99, largest hours value; must be < 2**HRS_W.
ACCUM_W, 19, width of sec_accum.
WRAP_MODE, 1, 1 = wrap to 0:00:00 after MAX_HRS:59:59; 0 = saturate at MAX_HRS:59:59.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  1 = divider advances; 0 = divider and time hold.
clear  in  1  synchronous clear of time, accumulator, divider, phase and overflow.
load_valid  in  1  loads load_time this cycle.
load_time  in  HRS_W+12  {hrs, min[5:0], sec[5:0]} value to load.
lap_req  in  1  requests capture of the current time.
HMS_time  out  HRS_W+12  {hrs, min[5:0], sec[5:0]}, binary fields.
sec_accum  out  ACCUM_W  seconds elapsed since reset, clear or load; wraps modulo 2**ACCUM_W.
half_sec_pulse  out  1  one-cycle pulse on each half-second tick.
sec_pulse  out  1  one-cycle pulse on every second half-second tick.
lap_time  out  HRS_W+12  captured time.
lap_valid  out  1  one-cycle pulse when lap_time updates.
overflow  out  1  wrap mode: one-cycle pulse on wrap. Saturate mode: sticky flag.
load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: all outputs are 0, divider is 0, phase is 0.
- Priority in any cycle: reset > clear > valid load > tick.
- Divider: increments when run=1; holds when run=0.
  - Terminal count is CYCLES_PER_HALF_SEC-1. When run=1 at terminal count, the divider returns to 0 and a tick occurs.
  - First tick after reset with run held high: half_sec_pulse is high in cycle N = CYCLES_PER_HALF_SEC (counting the first cycle after reset deasserts as cycle 1).
- Tick: on the tick edge, half_sec_pulse goes high and the phase bit toggles.
  - If phase was 1: sec_pulse goes high, seconds advance by one, and sec_accum increments, all on that same edge.
  - The new HMS_time is visible in the same cycle that sec_pulse is high.
- Carry chain: sec 59→0 carries to min; min 59→0 carries to hrs.
- At MAX_HRS:59:59, a one-second advance does the following:
  - WRAP_MODE=1: time becomes 0:00:00, overflow pulses for one cycle, sec_accum still increments.
  - WRAP_MODE=0: time holds, sec_accum holds, overflow sets and stays set. Pulses continue.
- clear: zeroes time, sec_accum, divider, phase, overflow and lap_time. No pulse is generated in that cycle.
- Load: valid when hrs ≤ MAX_HRS, min ≤ 59 and sec ≤ 59.
  - A valid load sets the time, zeroes divider, phase and sec_accum, and clears overflow. It suppresses any tick in that cycle.
  - An invalid load leaves all state unchanged (the divider keeps counting) and pulses load_err in the next cycle.
- Lap: lap_req captures the HMS_time value present before this edge's update. lap_time and lap_valid are valid in the next cycle.
  - Captures are accepted regardless of run, and lap_req held high captures every cycle.
  - lap_req coincident with clear: clear wins and lap_valid stays 0.
- Reset or clear asserted mid-count discards the partial divider count.

Decomposition:
- Package timebase_pkg holds:
  - SECS_PER_MIN=60 and MINS_PER_HR=60.
  - The field offsets for hrs, min and sec.
  - A function hms_in_range(hms, max_hrs).
- One sub-module, tick_gen, contains the divider, the phase bit, the run gating, clear/load synchronisation, and the registered half-second and second pulses.
- The time registers, carry logic, lap capture and overflow logic stay in timebase_counter.

Test Plan:
1. CYCLES_PER_HALF_SEC=4, run=1 after reset → half_sec_pulse in cycles 4, 8, 12; sec_pulse in cycles 8 and 16; HMS sec=1 in cycle 8, sec=2 in cycle 16; sec_accum=2 in cycle 16.
2. run=0 for 10 cycles with the divider at 2 → no pulses and state holds; the next half_sec_pulse comes 2 cycles after run returns to 1.
3. MAX_HRS=3, WRAP_MODE=1, load 2:59:59 → 3:00:00 after one second; load 3:59:59 → 0:00:00 with a one-cycle overflow pulse.
4. WRAP_MODE=0, load 3:59:59, run 3 seconds → HMS holds at 3:59:59, sec_accum=0, sec_pulse still fires, overflow stays 1 until clear.
5. lap_req in the same cycle as a sec tick at 0:00:05 → lap_time=0:00:05 and lap_valid next cycle, while HMS shows 0:00:06.
6. Load with min=60 → load_err pulses and time is unchanged. clear asserted together with load_valid and lap_req → all state 0, no lap_valid.

Source files
------------

// File: rtl/timebase_pkg.sv
// -----------------------------------------------------------------------------
// timebase_pkg
// Shared constants for the time-of-day counter: time-unit sizes, the bit
// offsets of the packed {hrs, min, sec} time word, and a range check for a
// candidate time value.
// -----------------------------------------------------------------------------
package timebase_pkg;

    localparam int SECS_PER_MIN = 60;
    localparam int MINS_PER_HR  = 60;

    // Packed time word layout: {hrs, min[5:0], sec[5:0]}
    localparam int FIELD_W = 6;
    localparam int SEC_LSB = 0;
    localparam int MIN_LSB = 6;
    localparam int HRS_LSB = 12;

    // Callers zero-extend their packed time word to 64 bits so one function
    // serves every HRS_W.
    function automatic logic hms_in_range(input logic [63:0] hms,
                                          input logic [63:0] max_hrs);
        logic [63:0] hrs_v;
        logic [63:0] min_v;
        logic [63:0] sec_v;
        hrs_v = hms >> HRS_LSB;
        min_v = (hms >> MIN_LSB) & 64'h3F;
        sec_v = (hms >> SEC_LSB) & 64'h3F;
        return (hrs_v <= max_hrs) &&
               (min_v < 64'(MINS_PER_HR)) &&
               (sec_v < 64'(SECS_PER_MIN));
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Half-second divider and phase bit. Produces a combinational second strobe
// for the time registers to act on, plus registered half-second and second
// pulses.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   run            : divider advances when 1, holds when 0
//   clear          : zeroes divider and phase, suppresses the tick
//   load           : an accepted time load; zeroes divider and phase
//   sec_tick       : high in the cycle whose edge completes a second
//   half_sec_pulse : registered one-cycle pulse per half-second tick
//   sec_pulse      : registered one-cycle pulse per second tick
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int CYCLES_PER_HALF_SEC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic load,
    output logic sec_tick,
    output logic half_sec_pulse,
    output logic sec_pulse
);

    localparam int              DIV_W = $clog2(CYCLES_PER_HALF_SEC);
    localparam logic [DIV_W-1:0] TERM = DIV_W'(CYCLES_PER_HALF_SEC - 1);

    logic [DIV_W-1:0] div_r;
    logic             phase_r;
    logic             half_r;
    logic             sec_r;
    logic             tick_s;

    // Clear and an accepted load both pre-empt a tick landing on the same edge.
    assign tick_s   = run & (div_r == TERM) & ~clear & ~load;
    assign sec_tick = tick_s & phase_r;

    assign half_sec_pulse = half_r;
    assign sec_pulse      = sec_r;

    // Divider, phase and registered tick pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r   <= '0;
            phase_r <= 1'b0;
            half_r  <= 1'b0;
            sec_r   <= 1'b0;
        end else if (clear || load) begin
            div_r   <= '0;
            phase_r <= 1'b0;
            half_r  <= 1'b0;
            sec_r   <= 1'b0;
        end else begin
            half_r  <= tick_s;
            sec_r   <= tick_s & phase_r;
            phase_r <= phase_r ^ tick_s;
            if (run) begin
                if (div_r == TERM) begin
                    div_r <= '0;
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end else begin
                div_r <= div_r;
            end
        end
    end

endmodule

// File: rtl/timebase_counter.sv
// -----------------------------------------------------------------------------
// timebase_counter
// Time-of-day counter: hours/minutes/seconds plus a free-running seconds
// accumulator, driven by the tick_gen divider. Supports run/pause, clear,
// time preload with range check, lap capture, and wrap or saturate at the
// maximum time. All outputs are registered.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   run            : 1 = divider advances, 0 = divider and time hold
//   clear          : zeroes time, accumulator, divider, phase, overflow, lap
//   load_valid     : load load_time this cycle (if in range)
//   load_time      : {hrs, min[5:0], sec[5:0]}
//   lap_req        : capture current time into lap_time
//   HMS_time       : {hrs, min[5:0], sec[5:0]}
//   sec_accum      : seconds since reset, clear or load (modulo 2**ACCUM_W)
//   half_sec_pulse : one-cycle pulse per half-second tick
//   sec_pulse      : one-cycle pulse per second tick
//   lap_time       : captured time; lap_valid pulses when it updates
//   overflow       : wrap mode pulse / saturate mode sticky flag
//   load_err       : one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module timebase_counter
    import timebase_pkg::*;
#(
    parameter int CYCLES_PER_HALF_SEC = 1024,
    parameter int HRS_W               = 8,
    parameter int MAX_HRS             = 99,
    parameter int ACCUM_W             = 19,
    parameter int WRAP_MODE           = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                clear,
    input  logic                load_valid,
    input  logic [HRS_W+11:0]   load_time,
    input  logic                lap_req,
    output logic [HRS_W+11:0]   HMS_time,
    output logic [ACCUM_W-1:0]  sec_accum,
    output logic                half_sec_pulse,
    output logic                sec_pulse,
    output logic [HRS_W+11:0]   lap_time,
    output logic                lap_valid,
    output logic                overflow,
    output logic                load_err
);

    localparam int HMS_W = HRS_W + 12;

    logic [HRS_W-1:0]   hrs_r;
    logic [FIELD_W-1:0] min_r;
    logic [FIELD_W-1:0] sec_r;
    logic [ACCUM_W-1:0] accum_r;
    logic [HMS_W-1:0]   lap_r;
    logic               lap_valid_r;
    logic               overflow_r;
    logic               load_err_r;

    logic               in_range_s;
    logic               load_ok_s;
    logic               sec_tick_s;
    logic               at_max_s;
    logic [HRS_W-1:0]   nxt_hrs_s;
    logic [FIELD_W-1:0] nxt_min_s;
    logic [FIELD_W-1:0] nxt_sec_s;

    assign in_range_s = hms_in_range(64'(load_time), 64'(MAX_HRS));
    assign load_ok_s  = load_valid & in_range_s;

    assign at_max_s = (hrs_r == HRS_W'(MAX_HRS)) &&
                      (min_r == FIELD_W'(MINS_PER_HR - 1)) &&
                      (sec_r == FIELD_W'(SECS_PER_MIN - 1));

    tick_gen #(
        .CYCLES_PER_HALF_SEC (CYCLES_PER_HALF_SEC)
    ) u_tick_gen (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .clear          (clear),
        .load           (load_ok_s),
        .sec_tick       (sec_tick_s),
        .half_sec_pulse (half_sec_pulse),
        .sec_pulse      (sec_pulse)
    );

    // One-second advance with sec->min->hrs carry; hrs wraps after MAX_HRS.
    always_comb begin
        nxt_sec_s = sec_r;
        nxt_min_s = min_r;
        nxt_hrs_s = hrs_r;
        if (sec_r == FIELD_W'(SECS_PER_MIN - 1)) begin
            nxt_sec_s = '0;
            if (min_r == FIELD_W'(MINS_PER_HR - 1)) begin
                nxt_min_s = '0;
                if (hrs_r == HRS_W'(MAX_HRS)) begin
                    nxt_hrs_s = '0;
                end else begin
                    nxt_hrs_s = hrs_r + HRS_W'(1);
                end
            end else begin
                nxt_min_s = min_r + FIELD_W'(1);
            end
        end else begin
            nxt_sec_s = sec_r + FIELD_W'(1);
        end
    end

    // Time, accumulator, overflow, lap and load-error registers.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hrs_r       <= '0;
            min_r       <= '0;
            sec_r       <= '0;
            accum_r     <= '0;
            overflow_r  <= 1'b0;
            lap_r       <= '0;
            lap_valid_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            // Lap sees the time as it stood before this edge's update.
            lap_valid_r <= lap_req;
            if (lap_req) begin
                lap_r <= {hrs_r, min_r, sec_r};
            end
            load_err_r <= load_valid & ~in_range_s;

            if (load_ok_s) begin
                hrs_r      <= load_time[HRS_LSB +: HRS_W];
                min_r      <= load_time[MIN_LSB +: FIELD_W];
                sec_r      <= load_time[SEC_LSB +: FIELD_W];
                accum_r    <= '0;
                overflow_r <= 1'b0;
            end else if (sec_tick_s && at_max_s && (WRAP_MODE == 0)) begin
                // Saturate: time and accumulator freeze, flag sticks.
                overflow_r <= 1'b1;
            end else if (sec_tick_s) begin
                hrs_r      <= nxt_hrs_s;
                min_r      <= nxt_min_s;
                sec_r      <= nxt_sec_s;
                accum_r    <= accum_r + ACCUM_W'(1);
                overflow_r <= (WRAP_MODE != 0) ? at_max_s : overflow_r;
            end else if (WRAP_MODE != 0) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign HMS_time  = {hrs_r, min_r, sec_r};
    assign sec_accum = accum_r;
    assign lap_time  = lap_r;
    assign lap_valid = lap_valid_r;
    assign overflow  = overflow_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_timebase_counter.sv
// -----------------------------------------------------------------------------
// tb_timebase_counter
// Two instances with a 4-cycle half-second and MAX_HRS=3: one in wrap mode,
// one in saturate mode. Expected events (with the cycle they must appear in)
// are queued up front; a monitor on the falling edge pops and compares one
// record whenever an instance shows a pulse or the stimulus raises a probe.
// Cycle k is the cycle after the k-th rising edge that sees reset low.
// -----------------------------------------------------------------------------
module tb_timebase_counter;

    typedef struct {
        int          cyc;
        logic        half;
        logic        sec;
        logic        lapv;
        logic        ovf;
        logic        lerr;
        logic [19:0] hms;
        logic [18:0] acc;
        logic [19:0] lap;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    ev_t  q_w[$];
    ev_t  q_s[$];
    logic probe_w;
    logic probe_s;

    // wrap-mode instance signals
    logic        w_run, w_clear, w_load_valid, w_lap_req;
    logic [19:0] w_load_time, w_hms, w_lap;
    logic [18:0] w_acc;
    logic        w_half, w_sec, w_lapv, w_ovf, w_lerr;

    // saturate-mode instance signals
    logic        s_run, s_clear, s_load_valid, s_lap_req;
    logic [19:0] s_load_time, s_hms, s_lap;
    logic [18:0] s_acc;
    logic        s_half, s_sec, s_lapv, s_ovf, s_lerr;

    timebase_counter #(
        .CYCLES_PER_HALF_SEC(4), .HRS_W(8), .MAX_HRS(3), .ACCUM_W(19), .WRAP_MODE(1)
    ) dut_w (
        .clock(clk), .reset(reset), .run(w_run), .clear(w_clear),
        .load_valid(w_load_valid), .load_time(w_load_time), .lap_req(w_lap_req),
        .HMS_time(w_hms), .sec_accum(w_acc), .half_sec_pulse(w_half),
        .sec_pulse(w_sec), .lap_time(w_lap), .lap_valid(w_lapv),
        .overflow(w_ovf), .load_err(w_lerr)
    );

    timebase_counter #(
        .CYCLES_PER_HALF_SEC(4), .HRS_W(8), .MAX_HRS(3), .ACCUM_W(19), .WRAP_MODE(0)
    ) dut_s (
        .clock(clk), .reset(reset), .run(s_run), .clear(s_clear),
        .load_valid(s_load_valid), .load_time(s_load_time), .lap_req(s_lap_req),
        .HMS_time(s_hms), .sec_accum(s_acc), .half_sec_pulse(s_half),
        .sec_pulse(s_sec), .lap_time(s_lap), .lap_valid(s_lapv),
        .overflow(s_ovf), .load_err(s_lerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number relative to reset release.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [19:0] t(input int h, input int m, input int s);
        return {8'(h), 6'(m), 6'(s)};
    endfunction

    task automatic push(input bit sat, input int c, input logic h, input logic s,
                        input logic lv, input logic ov, input logic le,
                        input logic [19:0] hm, input int ac, input logic [19:0] lp);
        ev_t e;
        e.cyc = c; e.half = h; e.sec = s; e.lapv = lv; e.ovf = ov; e.lerr = le;
        e.hms = hm; e.acc = 19'(ac); e.lap = lp;
        if (sat) q_s.push_back(e);
        else     q_w.push_back(e);
    endtask

    function automatic ev_t mk(input logic h, input logic s, input logic lv,
                               input logic ov, input logic le, input logic [19:0] hm,
                               input logic [18:0] ac, input logic [19:0] lp);
        ev_t e;
        e.cyc = cyc; e.half = h; e.sec = s; e.lapv = lv; e.ovf = ov; e.lerr = le;
        e.hms = hm; e.acc = ac; e.lap = lp;
        return e;
    endfunction

    task automatic cmp(input string nm, input ev_t e, input ev_t a);
        total++;
        if (!(e.cyc == a.cyc && e.half === a.half && e.sec === a.sec &&
              e.lapv === a.lapv && e.ovf === a.ovf && e.lerr === a.lerr &&
              e.hms === a.hms && e.acc === a.acc && e.lap === a.lap)) begin
            bad++;
            $display("FAIL %s: got cyc=%0d half=%b sec=%b lapv=%b ovf=%b lerr=%b hms=%h acc=%0d lap=%h; want cyc=%0d half=%b sec=%b lapv=%b ovf=%b lerr=%b hms=%h acc=%0d lap=%h",
                     nm, a.cyc, a.half, a.sec, a.lapv, a.ovf, a.lerr, a.hms, a.acc, a.lap,
                     e.cyc, e.half, e.sec, e.lapv, e.ovf, e.lerr, e.hms, e.acc, e.lap);
        end
    endtask

    // Monitor: one record per cycle in which an instance shows something.
    always @(negedge clk) begin
        if (w_half || w_sec || w_lapv || w_ovf || w_lerr || probe_w) begin
            if (q_w.size() == 0) begin
                total++; bad++;
                $display("FAIL wrap_unexpected: event at cyc=%0d hms=%h", cyc, w_hms);
            end else begin
                cmp("wrap_event", q_w.pop_front(),
                    mk(w_half, w_sec, w_lapv, w_ovf, w_lerr, w_hms, w_acc, w_lap));
            end
        end
        if (s_half || s_sec || s_lapv || s_lerr || probe_s) begin
            if (q_s.size() == 0) begin
                total++; bad++;
                $display("FAIL sat_unexpected: event at cyc=%0d hms=%h", cyc, s_hms);
            end else begin
                cmp("sat_event", q_s.pop_front(),
                    mk(s_half, s_sec, s_lapv, s_ovf, s_lerr, s_hms, s_acc, s_lap));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_probe(input bit sat);
        if (sat) probe_s = 1'b1; else probe_w = 1'b1;
        step();
        probe_s = 1'b0;
        probe_w = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: cyc=%0d still running, want done by cyc 90", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; probe_w = 1'b0; probe_s = 1'b0;
        w_run = 1'b0; w_clear = 1'b0; w_load_valid = 1'b0; w_lap_req = 1'b0; w_load_time = '0;
        s_run = 1'b0; s_clear = 1'b0; s_load_valid = 1'b0; s_lap_req = 1'b0; s_load_time = '0;

        // reset state of both instances
        push(0, 0, 0, 0, 0, 0, 0, t(0,0,0), 0, t(0,0,0));
        push(1, 0, 0, 0, 0, 0, 0, t(0,0,0), 0, t(0,0,0));
        step(); step();
        probe_w = 1'b1; probe_s = 1'b1;
        step();
        probe_w = 1'b0; probe_s = 1'b0;
        reset = 1'b0; w_run = 1'b1;

        // wrap instance:      sat cyc   h  s  lv ov le  hms          acc lap
        push(0,  4, 1, 0, 0, 0, 0, t(0,0,1-1),  0, t(0,0,0));
        push(0,  8, 1, 1, 0, 0, 0, t(0,0,1),    1, t(0,0,0));
        push(0, 12, 1, 0, 0, 0, 0, t(0,0,1),    1, t(0,0,0));
        push(0, 16, 1, 1, 0, 0, 0, t(0,0,2),    2, t(0,0,0));
        push(0, 24, 0, 0, 0, 0, 0, t(0,0,2),    2, t(0,0,0));
        push(0, 30, 1, 0, 0, 0, 0, t(0,0,2),    2, t(0,0,0));
        push(0, 34, 1, 1, 0, 0, 0, t(0,0,3),    3, t(0,0,0));
        push(0, 36, 0, 0, 0, 0, 0, t(2,59,59),  0, t(0,0,0));
        push(0, 40, 1, 0, 0, 0, 0, t(2,59,59),  0, t(0,0,0));
        push(0, 44, 1, 1, 0, 0, 0, t(3,0,0),    1, t(0,0,0));
        push(0, 50, 1, 0, 0, 0, 0, t(3,59,59),  0, t(0,0,0));
        push(0, 54, 1, 1, 0, 1, 0, t(0,0,0),    1, t(0,0,0));
        push(0, 55, 0, 0, 0, 0, 0, t(0,0,0),    1, t(0,0,0));
        push(0, 61, 1, 0, 0, 0, 0, t(0,0,5),    0, t(0,0,0));
        push(0, 65, 1, 1, 1, 0, 0, t(0,0,6),    1, t(0,0,5));
        push(0, 67, 0, 0, 0, 0, 1, t(0,0,6),    1, t(0,0,5));
        push(0, 69, 1, 0, 0, 0, 0, t(0,0,6),    1, t(0,0,5));
        push(0, 71, 0, 0, 0, 0, 0, t(0,0,0),    0, t(0,0,0));
        push(0, 75, 1, 0, 0, 0, 0, t(0,0,0),    0, t(0,0,0));
        push(0, 77, 0, 0, 0, 0, 1, t(0,0,0),    0, t(0,0,0));
        push(0, 79, 1, 1, 1, 0, 0, t(0,0,1),    1, t(0,0,0));
        push(0, 80, 0, 0, 1, 0, 0, t(0,0,1),    1, t(0,0,1));

        // saturate instance: load 3:59:59, run three seconds, then clear
        push(1,  7, 1, 0, 0, 0, 0, t(3,59,59),  0, t(0,0,0));
        for (int k = 0; k < 5; k++) begin
            push(1, 11 + 4*k, 1, (k % 2 == 0) ? 1'b1 : 1'b0, 0, 1, 0, t(3,59,59), 0, t(0,0,0));
        end
        push(1, 29, 0, 0, 0, 1, 0, t(3,59,59),  0, t(0,0,0));
        push(1, 31, 0, 0, 0, 0, 0, t(0,0,0),    0, t(0,0,0));

        fork
            begin
                // pause with divider at 2, resume
                wait_until(18); w_run = 1'b0;
                wait_until(24); pulse_probe(0);
                wait_until(28); w_run = 1'b1;
                // load 2:59:59, then 3:59:59 to exercise wrap
                wait_until(35); w_load_valid = 1'b1; w_load_time = t(2,59,59);
                step(); w_load_valid = 1'b0;
                pulse_probe(0);
                wait_until(45); w_load_valid = 1'b1; w_load_time = t(3,59,59);
                step(); w_load_valid = 1'b0;
                wait_until(55); pulse_probe(0);
                // load 0:00:05 and lap on the next second tick
                w_load_valid = 1'b1; w_load_time = t(0,0,5);
                step(); w_load_valid = 1'b0;
                wait_until(64); w_lap_req = 1'b1;
                step(); w_lap_req = 1'b0;
                // invalid load: min = 60
                wait_until(66); w_load_valid = 1'b1; w_load_time = {8'd3, 6'd60, 6'd0};
                step(); w_load_valid = 1'b0;
                // clear together with a valid load and a lap request
                wait_until(70);
                w_clear = 1'b1; w_load_valid = 1'b1; w_load_time = t(1,2,3); w_lap_req = 1'b1;
                step();
                w_clear = 1'b0; w_load_valid = 1'b0; w_lap_req = 1'b0;
                pulse_probe(0);
                // invalid load: hrs above MAX_HRS
                wait_until(76); w_load_valid = 1'b1; w_load_time = t(4,0,0);
                step(); w_load_valid = 1'b0;
                // lap held for two cycles
                wait_until(78); w_lap_req = 1'b1;
                step(); step();
                w_lap_req = 1'b0; w_run = 1'b0;
                wait_until(84);
            end
            begin
                wait_until(2);
                s_run = 1'b1; s_load_valid = 1'b1; s_load_time = t(3,59,59);
                step(); s_load_valid = 1'b0;
                wait_until(29); pulse_probe(1);
                s_clear = 1'b1;
                step(); s_clear = 1'b0; s_run = 1'b0;
                pulse_probe(1);
            end
        join

        step(); step();
        while (q_w.size() > 0) begin
            total++; bad++;
            $display("FAIL wrap_missing: no event at cyc=%0d, want hms=%h", q_w[0].cyc, q_w[0].hms);
            void'(q_w.pop_front());
        end
        while (q_s.size() > 0) begin
            total++; bad++;
            $display("FAIL sat_missing: no event at cyc=%0d, want hms=%h", q_s[0].cyc, q_s[0].hms);
            void'(q_s.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
